dmx8_4bits_reg: RTL and testbench
=================================

Name: dmx8_4bits_reg

Overview:
- Registered 4-bit 1-to-8 demultiplexer: the distribution-side counterpart of the 4-bit 8-to-1 selector in the ALU datapath.
- Takes one 4-bit word plus a 3-bit lane select (s2,s1,s0) under a valid/ready handshake. Writes the word into one of eight holding registers.
- Each lane holds its word, with a per-lane valid flag, until the downstream consumer acknowledges it.
- Feeds ALU operand/result consumers that drain at independent rates.

Parameters:
- WIDTH, 4, data width of the input word and of each lane register.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- d  input  WIDTH  input data word.
- s2  input  1  lane select MSB.
- s1  input  1  lane select middle bit.
- s0  input  1  lane select LSB; lane index = {s2,s1,s0}.
- in_valid  input  1  d and select are valid this cycle.
- in_ready  output  1  block accepts the word this cycle.
- y0..y7  output  WIDTH each  lane holding registers; lane 0 = select 000 … lane 7 = select 111.
- vld  output  8  vld[i] = lane i holds an unconsumed word.
- ack  input  8  ack[i] = consumer takes lane i this cycle; ignored when vld[i]=0.
- occ  output  4  number of lanes with vld set (0..8).
- drop  output  1  sticky flag: in_valid was asserted to a full lane.

Behaviour:
- Reset (asynchronous, takes effect immediately, held while reset=1):
  - y0..y7 = 0, vld = 0, occ = 0, drop = 0.
  - An in-flight handshake is discarded; no write occurs in any cycle where reset is high.
- Lane index k = {s2,s1,s0}.
- in_ready is combinational: in_ready = ~vld[k] | ack[k]. This is pass-through on simultaneous drain.
  - in_ready may be observed when in_valid=0. It depends only on the current select and ack.
- Accept: when in_valid & in_ready at a rising edge:
  - y_k <= d and vld[k] <= 1.
  - Latency is 1 cycle: the word and flag are visible on the cycle after acceptance.
- Consume: when ack[i] & vld[i] at a rising edge and lane i is not being written that cycle, vld[i] <= 0.
  - y_i keeps its old value; contents are only meaningful while vld[i]=1.
- Simultaneous ack[k] and accept to the same lane k: the old word is consumed, the new word is loaded, and vld[k] stays 1.
- Accepts to lane k and acks to other lanes in the same cycle are independent; all take effect.
- ack[i] with vld[i]=0 has no effect.
- occ is registered. Each cycle: occ <= occ + (accept that sets a previously clear flag) - (number of flags cleared). It always equals popcount(vld) and never exceeds 8 or wraps.
- drop: set when in_valid=1 and in_ready=0 at a rising edge. It stays set until reset. The rejected word is not stored and the existing lane content is unchanged.
- Upstream must hold d and select stable while in_valid=1 and in_ready=0. The block does not check this.
- No state machine beyond the per-lane flags: each lane is EMPTY (vld=0) or FULL (vld=1).
  - EMPTY->FULL on accept.
  - FULL->EMPTY on ack without accept.
  - FULL->FULL on accept+ack.
- Unused/X select while in_valid=0 must not alter any lane.

Test Plan:
- Reset, then drive d=4'hA, select 101, in_valid one cycle -> in_ready=1; next cycle y5=4'hA, vld=8'b0010_0000, occ=1; all other lanes 0.
- Fill all eight lanes with d=lane index+1 (selects 000..111) -> vld=8'hFF, occ=8, y0..y7 = 1..8, drop=0.
- With lane 3 full (y3=4'h4), drive in_valid, select 011, d=4'hF, ack=0 -> in_ready=0; y3 stays 4'h4; drop=1 next cycle and remains 1.
- Lane 2 full with 4'h3: same cycle, in_valid with select 010, d=4'hC, and ack[2]=1 -> in_ready=1; next cycle y2=4'hC, vld[2]=1, occ unchanged.
- occ=8; ack=8'hFF with in_valid=0 -> next cycle vld=0, occ=0; ack on empty lanes the following cycle -> occ stays 0.
- Assert reset mid-cycle while in_valid=1 with lanes partly full -> outputs clear immediately without a clock edge. After release, the first edge with in_valid=0 leaves vld=0, occ=0, drop=0.

Source files
------------

// File: rtl/dmx8_4bits_reg.sv
// Registered 4-bit 1-to-8 demultiplexer with per-lane valid flags.
// A word is written into the lane chosen by {s2,s1,s0} under a valid/ready
// handshake. The lane then holds the word until its consumer acknowledges it.
module dmx8_4bits_reg #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  input  logic             s2,
  input  logic             s1,
  input  logic             s0,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] y0,
  output logic [WIDTH-1:0] y1,
  output logic [WIDTH-1:0] y2,
  output logic [WIDTH-1:0] y3,
  output logic [WIDTH-1:0] y4,
  output logic [WIDTH-1:0] y5,
  output logic [WIDTH-1:0] y6,
  output logic [WIDTH-1:0] y7,
  output logic [7:0]       vld,
  input  logic [7:0]       ack,
  output logic [3:0]       occ,
  output logic             drop
);

  logic [2:0]       sel;
  logic             accept;
  logic             set_new;
  logic [7:0]       wr;
  logic [7:0]       clr;
  logic [7:0]       vld_reg;
  logic [7:0]       vld_next;
  logic [3:0]       occ_reg;
  logic [3:0]       occ_next;
  logic [3:0]       clr_cnt;
  logic             drop_reg;
  logic [WIDTH-1:0] lane_reg [8];

  assign sel = {s2, s1, s0};

  // A full lane can still take a word when its consumer drains it this cycle.
  assign in_ready = ~vld_reg[sel] | ack[sel];
  assign accept   = in_valid & in_ready;

  // An accept only grows occupancy when the target lane was empty.
  assign set_new  = accept & ~vld_reg[sel];

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_lane
      assign wr[gi]       = accept && (sel == 3'(gi));
      // A write to the same lane wins over the ack: old word consumed, new loaded.
      assign clr[gi]      = ack[gi] & vld_reg[gi] & ~wr[gi];
      assign vld_next[gi] = wr[gi] | (vld_reg[gi] & ~clr[gi]);

      // Lane data register: loads only on an accepted write to this lane.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          lane_reg[gi] <= '0;
        end else if (wr[gi]) begin
          lane_reg[gi] <= d;
        end
      end
    end
  endgenerate

  // Occupancy update: add the newly filled lane, subtract drained lanes.
  always_comb begin
    clr_cnt = '0;
    for (int i = 0; i < 8; i++) begin
      clr_cnt = clr_cnt + {3'b000, clr[i]};
    end
    occ_next = occ_reg + {3'b000, set_new} - clr_cnt;
  end

  // Flag, occupancy and sticky-drop state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_reg  <= '0;
      occ_reg  <= '0;
      drop_reg <= 1'b0;
    end else begin
      vld_reg  <= vld_next;
      occ_reg  <= occ_next;
      if (in_valid && !in_ready) begin
        drop_reg <= 1'b1;
      end
    end
  end

  assign vld  = vld_reg;
  assign occ  = occ_reg;
  assign drop = drop_reg;
  assign y0   = lane_reg[0];
  assign y1   = lane_reg[1];
  assign y2   = lane_reg[2];
  assign y3   = lane_reg[3];
  assign y4   = lane_reg[4];
  assign y5   = lane_reg[5];
  assign y6   = lane_reg[6];
  assign y7   = lane_reg[7];

endmodule

// File: tb/tb_dmx8_4bits_reg.sv
// Self-checking bench for dmx8_4bits_reg: directed scenarios with literal
// expectations plus randomized traffic compared each cycle against a lane model.
module tb_dmx8_4bits_reg;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] d;
  logic [2:0] sel;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] y0, y1, y2, y3, y4, y5, y6, y7;
  logic [7:0] vld;
  logic [7:0] ack;
  logic [3:0] occ;
  logic       drop;

  int checks   = 0;
  int failures = 0;

  // Behavioural model: eight mailbox slots with a full flag each.
  logic [3:0] m_y [8];
  bit         m_v [8];
  bit         m_drop;

  dmx8_4bits_reg #(.WIDTH(4)) dut (
    .clk(clk), .reset(reset), .d(d),
    .s2(sel[2]), .s1(sel[1]), .s0(sel[0]),
    .in_valid(in_valid), .in_ready(in_ready),
    .y0(y0), .y1(y1), .y2(y2), .y3(y3), .y4(y4), .y5(y5), .y6(y6), .y7(y7),
    .vld(vld), .ack(ack), .occ(occ), .drop(drop)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] dut_y(input int i);
    case (i)
      0: return y0;
      1: return y1;
      2: return y2;
      3: return y3;
      4: return y4;
      5: return y5;
      6: return y6;
      default: return y7;
    endcase
  endfunction

  function automatic int model_occ();
    int n = 0;
    for (int i = 0; i < 8; i++) n += m_v[i] ? 1 : 0;
    return n;
  endfunction

  function automatic logic [7:0] model_vld();
    logic [7:0] v;
    for (int i = 0; i < 8; i++) v[i] = m_v[i];
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h time=%0t", name, act, exp, $time);
    end
  endtask

  // Model update: a slot is free if empty or being drained right now.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) begin
        m_y[i] = 4'h0;
        m_v[i] = 1'b0;
      end
      m_drop = 1'b0;
    end else begin
      int  k;
      bit  take;
      k    = int'(sel);
      take = in_valid && (!m_v[k] || ack[k]);
      for (int i = 0; i < 8; i++) if (ack[i]) m_v[i] = 1'b0;
      if (take) begin
        m_y[k] = d;
        m_v[k] = 1'b1;
      end
      if (in_valid && !take) m_drop = 1'b1;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    int k;
    k = int'(sel);
    chk("cyc_vld", int'(vld), int'(model_vld()));
    chk("cyc_occ", int'(occ), model_occ());
    chk("cyc_drop", int'(drop), int'(m_drop));
    chk("cyc_ready", int'(in_ready), int'(!m_v[k] || ack[k]));
    for (int i = 0; i < 8; i++) chk($sformatf("cyc_y%0d", i), int'(dut_y(i)), int'(m_y[i]));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; d = '0; sel = '0; in_valid = 1'b0; ack = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_vld", int'(vld), 0);
    chk("rst_occ", int'(occ), 0);
    chk("rst_drop", int'(drop), 0);

    // Single write to lane 5.
    d = 4'hA; sel = 3'd5; in_valid = 1'b1;
    #1 chk("t1_ready", int'(in_ready), 1);
    tick(); in_valid = 1'b0;
    chk("t1_y5", int'(y5), 4'hA);
    chk("t1_vld", int'(vld), 8'h20);
    chk("t1_occ", int'(occ), 1);
    chk("t1_y0", int'(y0), 0);
    chk("t1_y7", int'(y7), 0);

    // Fill all lanes with index+1; ack on the written lane drains lane 5's old word.
    for (int i = 0; i < 8; i++) begin
      d = 4'(i + 1); sel = 3'(i); in_valid = 1'b1; ack = 8'(1 << i);
      tick();
    end
    in_valid = 1'b0; ack = '0;
    chk("t2_vld", int'(vld), 8'hFF);
    chk("t2_occ", int'(occ), 8);
    chk("t2_drop", int'(drop), 0);
    for (int i = 0; i < 8; i++) chk($sformatf("t2_y%0d", i), int'(dut_y(i)), i + 1);

    // Write to full lane 3 without ack is rejected.
    d = 4'hF; sel = 3'd3; in_valid = 1'b1;
    #1 chk("t3_ready", int'(in_ready), 0);
    tick(); in_valid = 1'b0;
    chk("t3_y3", int'(y3), 4'h4);
    chk("t3_drop", int'(drop), 1);
    tick();
    chk("t3_drop_sticky", int'(drop), 1);

    // Pass-through: write and ack lane 2 together.
    d = 4'hC; sel = 3'd2; in_valid = 1'b1; ack = 8'h04;
    #1 chk("t4_ready", int'(in_ready), 1);
    tick(); in_valid = 1'b0; ack = '0;
    chk("t4_y2", int'(y2), 4'hC);
    chk("t4_vld2", int'(vld[2]), 1);
    chk("t4_occ", int'(occ), 8);

    // Drain everything, then ack empty lanes.
    ack = 8'hFF;
    tick();
    chk("t5_vld", int'(vld), 0);
    chk("t5_occ", int'(occ), 0);
    tick();
    chk("t5_occ_empty_ack", int'(occ), 0);
    ack = '0;

    // Randomized traffic, checked by the per-cycle compare process.
    for (int n = 0; n < 600; n++) begin
      d        = 4'($urandom);
      sel      = 3'($urandom);
      in_valid = ($urandom_range(0, 99) < 60);
      ack      = 8'($urandom) & 8'($urandom);
      tick();
    end

    // Partially fill, then assert reset between edges with a write pending.
    ack = '0;
    for (int i = 0; i < 3; i++) begin
      d = 4'(i + 9); sel = 3'(i); in_valid = 1'b1;
      tick();
    end
    d = 4'h7; sel = 3'd6; in_valid = 1'b1;
    #1 reset = 1'b1;
    #1;
    chk("t6_async_vld", int'(vld), 0);
    chk("t6_async_occ", int'(occ), 0);
    chk("t6_async_drop", int'(drop), 0);
    chk("t6_async_y0", int'(y0), 0);
    tick();
    chk("t6_hold_vld", int'(vld), 0);
    in_valid = 1'b0;
    #1 reset = 1'b0;
    tick();
    chk("t6_post_vld", int'(vld), 0);
    chk("t6_post_occ", int'(occ), 0);
    chk("t6_post_drop", int'(drop), 0);

    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
